// File: rtl/nonce_cycle_sequencer_if.sv
// nonce_cycle_sequencer_if: bundle between the round/nonce sequencer and the hash datapath
interface nonce_cycle_sequencer_if;
    logic        solveEn;
    logic [5:0]  cycle;
    logic [31:0] nonce;
    logic        passStart;
    logic        passLast;
    logic        exhausted;

    modport master (
        output solveEn,
        input  cycle, nonce, passStart, passLast, exhausted
    );

    modport slave (
        input  solveEn,
        output cycle, nonce, passStart, passLast, exhausted
    );
endinterface

// File: rtl/nonce_cycle_sequencer.sv
// nonce_cycle_sequencer: steps the SHA-256 round index and advances the candidate nonce once per pass
module nonce_cycle_sequencer #(
    parameter logic [31:0] NONCE_START = 32'd0,
    parameter logic [31:0] NONCE_STEP  = 32'd1,
    parameter int          ROUNDS      = 64
) (
    input  logic                    clk,
    input  logic                    clearCounter,
    nonce_cycle_sequencer_if.slave  bus
);
    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    logic [5:0]  cycle_q;
    logic [31:0] nonce_q;
    logic        exhausted_q;
    logic        advance;
    logic        at_last;
    logic [32:0] next_sum;

    always_comb begin
        advance  = bus.solveEn && !exhausted_q;
        at_last  = cycle_q == LAST;
        next_sum = {1'b0, nonce_q} + {1'b0, NONCE_STEP};
    end

    // The nonce moves on the same edge the round index wraps, so it is stable for a whole pass.
    always_ff @(posedge clk) begin
        if (clearCounter) begin
            cycle_q     <= '0;
            nonce_q     <= NONCE_START;
            exhausted_q <= 1'b0;
        end else if (advance) begin
            cycle_q <= at_last ? 6'd0 : cycle_q + 6'd1;
            if (at_last) begin
                nonce_q     <= next_sum[31:0];
                exhausted_q <= next_sum[32];
            end
        end
    end

    assign bus.cycle     = cycle_q;
    assign bus.nonce     = nonce_q;
    assign bus.exhausted = exhausted_q;
    assign bus.passStart = advance && cycle_q == 6'd0;
    assign bus.passLast  = advance && at_last;
endmodule

// File: tb/tb_nonce_cycle_sequencer.sv
// tb_nonce_cycle_sequencer: scoreboard bench over three parameterisations of the sequencer
module tb_nonce_cycle_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr[3];
    nonce_cycle_sequencer_if b0 ();
    nonce_cycle_sequencer_if b1 ();
    nonce_cycle_sequencer_if b2 ();

    nonce_cycle_sequencer dut_a (.clk(clk), .clearCounter(clr[0]), .bus(b0.slave));
    nonce_cycle_sequencer #(.NONCE_START(32'd5)) dut_b (.clk(clk), .clearCounter(clr[1]), .bus(b1.slave));
    nonce_cycle_sequencer #(.NONCE_START(32'hFFFFFFFC), .NONCE_STEP(32'd4)) dut_c (.clk(clk), .clearCounter(clr[2]), .bus(b2.slave));

    longint st[3] = '{64'd0, 64'd5, 64'hFFFFFFFC};
    longint sp[3] = '{64'd1, 64'd1, 64'd4};
    int t[3];
    int compared = 0;
    int mismatched = 0;
    logic [40:0] q[$];
    logic [31:0] nq[$];

    // Expected {cycle, nonce, exhausted, passStart, passLast} after t enabled edges since reset.
    function automatic logic [40:0] expect_of(int w, logic en);
        longint p = longint'(t[w] / 64);
        longint s = st[w] + sp[w] * p;
        longint pe;
        logic [5:0] c = 6'(t[w] % 64);
        if (s >= 64'h1_0000_0000) begin
            pe = (64'h1_0000_0000 - st[w] + sp[w] - 1) / sp[w];
            s = st[w] + sp[w] * pe;
            return {6'd0, s[31:0], 1'b1, 1'b0, 1'b0};
        end
        return {c, s[31:0], 1'b0, en && c == 6'd0, en && c == 6'd63};
    endfunction

    function automatic logic [40:0] obs(int w);
        case (w)
            0:       return {b0.cycle, b0.nonce, b0.exhausted, b0.passStart, b0.passLast};
            1:       return {b1.cycle, b1.nonce, b1.exhausted, b1.passStart, b1.passLast};
            default: return {b2.cycle, b2.nonce, b2.exhausted, b2.passStart, b2.passLast};
        endcase
    endfunction

    task automatic step(int w, logic c, logic en);
        clr[w] = c;
        case (w)
            0:       b0.solveEn = en;
            1:       b1.solveEn = en;
            default: b2.solveEn = en;
        endcase
        if (c) t[w] = 0;
        else if (en) t[w]++;
        q.push_back(expect_of(w, en));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [40:0] e;
        step(0, 1'b1, 1'b1);
        e = q.pop_front();
        compared++;
        if (obs(0) !== e) begin
            mismatched++;
            $display("FAIL reset: got %h expected %h", obs(0), e);
        end
    endtask

    task automatic test_count();
        logic [40:0] e;
        for (int i = 0; i < 130; i++) begin
            step(0, 1'b0, 1'b1);
            e = q.pop_front();
            compared++;
            if (obs(0) !== e) begin
                mismatched++;
                $display("FAIL count[%0d]: got %h expected %h", i, obs(0), e);
            end
        end
    endtask

    task automatic test_gating();
        logic [40:0] e;
        for (int i = 0; i < 100; i++) begin
            step(0, 1'b0, 1'b1);
            e = q.pop_front();
            compared++;
            if (obs(0) !== e) begin
                mismatched++;
                $display("FAIL gate_run: got %h expected %h", obs(0), e);
            end
            if (t[0] % 64 == 20) break;
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b0, 1'b0);
            e = q.pop_front();
            compared++;
            if (obs(0) !== e || b0.cycle !== 6'd20) begin
                mismatched++;
                $display("FAIL gate_hold[%0d]: got %h expected %h", i, obs(0), e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 1'b1);
            e = q.pop_front();
            compared++;
            if (obs(0) !== e) begin
                mismatched++;
                $display("FAIL gate_resume[%0d]: got %h expected %h", i, obs(0), e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [40:0] e;
        while (t[0] < 3 * 64 + 37) begin
            step(0, 1'b0, 1'b1);
            e = q.pop_front();
            compared++;
            if (obs(0) !== e) begin
                mismatched++;
                $display("FAIL mid_run: got %h expected %h", obs(0), e);
            end
        end
        compared++;
        if (b0.cycle !== 6'd37 || b0.nonce !== 32'd3) begin
            mismatched++;
            $display("FAIL mid_pre: got cycle %0d nonce %0d expected 37 3", b0.cycle, b0.nonce);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, i == 0, 1'b1);
            e = q.pop_front();
            compared++;
            if (obs(0) !== e) begin
                mismatched++;
                $display("FAIL mid_reset[%0d]: got %h expected %h", i, obs(0), e);
            end
        end
    endtask

    task automatic test_start();
        logic [40:0] e;
        logic [31:0] n;
        for (int p = 0; p < 4; p++) nq.push_back(32'd5 + 32'(p));
        step(1, 1'b1, 1'b0);
        void'(q.pop_front());
        for (int i = 0; i < 4 * 64 + 2; i++) begin
            step(1, 1'b0, 1'b1);
            e = q.pop_front();
            compared++;
            if (obs(1) !== e) begin
                mismatched++;
                $display("FAIL start[%0d]: got %h expected %h", i, obs(1), e);
            end
            if (b1.cycle == 6'd1 && nq.size() > 0) begin
                n = nq.pop_front();
                compared++;
                if (b1.nonce !== n) begin
                    mismatched++;
                    $display("FAIL start_nonce: got %h expected %h", b1.nonce, n);
                end
            end
        end
        compared++;
        if (nq.size() != 0) begin
            mismatched++;
            $display("FAIL start_passes: got %0d unconsumed expected 0", nq.size());
        end
    endtask

    task automatic test_wrap();
        logic [40:0] e;
        step(2, 1'b1, 1'b0);
        e = q.pop_front();
        compared++;
        if (obs(2) !== e) begin
            mismatched++;
            $display("FAIL wrap_reset: got %h expected %h", obs(2), e);
        end
        for (int i = 0; i < 72; i++) begin
            step(2, 1'b0, i != 68);
            e = q.pop_front();
            compared++;
            if (obs(2) !== e) begin
                mismatched++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs(2), e);
            end
        end
        compared++;
        if (b2.nonce !== 32'd0 || b2.exhausted !== 1'b1 || b2.cycle !== 6'd0) begin
            mismatched++;
            $display("FAIL wrap_final: got n=%h e=%b c=%0d expected 0 1 0", b2.nonce, b2.exhausted, b2.cycle);
        end
        for (int i = 0; i < 2; i++) begin
            step(2, i == 0, 1'b1);
            e = q.pop_front();
            compared++;
            if (obs(2) !== e) begin
                mismatched++;
                $display("FAIL wrap_clear[%0d]: got %h expected %h", i, obs(2), e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b1;
            t[i] = 0;
        end
        b0.solveEn = 1'b0;
        b1.solveEn = 1'b0;
        b2.solveEn = 1'b0;
        @(negedge clk);
        test_reset();
        test_count();
        test_gating();
        test_mid_reset();
        test_start();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
